// File: rtl/lamp_pkg.sv
// Shared definitions for the three-lamp traffic-light bus and its sequence monitor.
// Lamp codes, phase and error encodings, monitor states and decode helpers.
package lamp_pkg;

    // Lamp bus codes: bit 0 of light[0:2] is the red lamp.
    localparam logic [0:2] LIGHT_RED    = 3'b100;
    localparam logic [0:2] LIGHT_GREEN  = 3'b010;
    localparam logic [0:2] LIGHT_YELLOW = 3'b001;

    // Names used by the cyclic lamp controller.
    localparam logic [0:2] RED    = LIGHT_RED;
    localparam logic [0:2] GREEN  = LIGHT_GREEN;
    localparam logic [0:2] YELLOW = LIGHT_YELLOW;

    localparam logic [1:0] PH_GREEN  = 2'd0;
    localparam logic [1:0] PH_YELLOW = 2'd1;
    localparam logic [1:0] PH_RED    = 2'd2;
    localparam logic [1:0] PH_NONE   = 2'd3;

    localparam logic [1:0] ERR_NONE   = 2'd0;
    localparam logic [1:0] ERR_ONEHOT = 2'd1;
    localparam logic [1:0] ERR_TRANS  = 2'd2;
    localparam logic [1:0] ERR_DWELL  = 2'd3;

    localparam int DWELL_W = 8;

    typedef enum logic [2:0] {
        MON_UNLOCKED,
        MON_GREEN,
        MON_YELLOW,
        MON_RED,
        MON_FAULT
    } mon_state_t;

    // Any code that is not exactly one lamp decodes to PH_NONE.
    function automatic logic [1:0] light_to_phase(input logic [0:2] l);
        logic [1:0] p;
        case (l)
            LIGHT_GREEN:  p = PH_GREEN;
            LIGHT_YELLOW: p = PH_YELLOW;
            LIGHT_RED:    p = PH_RED;
            default:      p = PH_NONE;
        endcase
        return p;
    endfunction

    function automatic logic [1:0] next_phase(input logic [1:0] p);
        logic [1:0] n;
        case (p)
            PH_GREEN:  n = PH_YELLOW;
            PH_YELLOW: n = PH_RED;
            default:   n = PH_GREEN;
        endcase
        return n;
    endfunction

    function automatic mon_state_t phase_to_state(input logic [1:0] p);
        mon_state_t s;
        case (p)
            PH_GREEN:  s = MON_GREEN;
            PH_YELLOW: s = MON_YELLOW;
            PH_RED:    s = MON_RED;
            default:   s = MON_UNLOCKED;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/lamp_dwell_counter.sv
// Saturating 8-bit dwell counter with load-1 / increment controls.
// over is high once another hold would push the count past MAX_DWELL.
module lamp_dwell_counter
    import lamp_pkg::*;
#(
    parameter int MAX_DWELL = 1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic load_one,
    input  logic incr,
    output logic over
);

    logic [DWELL_W-1:0] count_reg;
    logic [DWELL_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (load_one) begin
            count_next = DWELL_W'(1);
        end else if (incr && (count_reg != '1)) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign over = (count_reg >= DWELL_W'(MAX_DWELL));

endmodule

// File: rtl/lamp_sequence_monitor.sv
// Supervisor for the traffic-light lamp bus: locks onto GREEN->YELLOW->RED, counts cycles, flags faults.
// Define LAMP_MON_DWELL_CHECK_EN to also fault a colour held longer than MAX_DWELL cycles.
module lamp_sequence_monitor
    import lamp_pkg::*;
#(
    parameter int CNT_W     = 8,
    parameter int MAX_DWELL = 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [0:2]       light,
    input  logic             err_clr,
    output logic             locked,
    output logic [1:0]       phase,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [CNT_W-1:0] cycle_count
);

    if (MAX_DWELL < 1 || MAX_DWELL > 255) begin : g_bad_max_dwell
        $error("MAX_DWELL must be within 1..255");
    end

    mon_state_t       state_reg, state_next;
    logic [1:0]       phase_reg, phase_next;
    logic [1:0]       err_code_reg, err_code_next;
    logic [CNT_W-1:0] cycle_count_reg, cycle_count_next;
    logic             locked_reg, locked_next;
    logic             error_reg, error_next;
    logic [1:0]       sample_phase;

    assign sample_phase = light_to_phase(light);

`ifdef LAMP_MON_DWELL_CHECK_EN
    logic dwell_load;
    logic dwell_incr;
    logic dwell_over;

    lamp_dwell_counter #(
        .MAX_DWELL (MAX_DWELL)
    ) u_dwell (
        .clock    (clock),
        .reset_n  (reset_n),
        .load_one (dwell_load),
        .incr     (dwell_incr),
        .over     (dwell_over)
    );
`endif

    always_comb begin
        state_next       = state_reg;
        phase_next       = phase_reg;
        err_code_next    = err_code_reg;
        cycle_count_next = cycle_count_reg;
`ifdef LAMP_MON_DWELL_CHECK_EN
        dwell_load       = 1'b0;
        dwell_incr       = 1'b0;
`endif
        // err_clr wins over whatever is on the bus this edge.
        if (err_clr) begin
            state_next    = MON_UNLOCKED;
            phase_next    = PH_NONE;
            err_code_next = ERR_NONE;
        end else begin
            case (state_reg)
                MON_UNLOCKED: begin
                    if (sample_phase != PH_NONE) begin
                        state_next = phase_to_state(sample_phase);
                        phase_next = sample_phase;
`ifdef LAMP_MON_DWELL_CHECK_EN
                        dwell_load = 1'b1;
`endif
                    end
                end
                MON_GREEN, MON_YELLOW, MON_RED: begin
                    if (sample_phase == PH_NONE) begin
                        state_next    = MON_FAULT;
                        phase_next    = PH_NONE;
                        err_code_next = ERR_ONEHOT;
                    end else if (sample_phase == next_phase(phase_reg)) begin
                        state_next = phase_to_state(sample_phase);
                        phase_next = sample_phase;
`ifdef LAMP_MON_DWELL_CHECK_EN
                        dwell_load = 1'b1;
`endif
                        if (phase_reg == PH_RED && cycle_count_reg != '1) begin
                            cycle_count_next = cycle_count_reg + 1'b1;
                        end
                    end else if (sample_phase != phase_reg) begin
                        state_next    = MON_FAULT;
                        phase_next    = PH_NONE;
                        err_code_next = ERR_TRANS;
`ifdef LAMP_MON_DWELL_CHECK_EN
                    end else if (dwell_over) begin
                        state_next    = MON_FAULT;
                        phase_next    = PH_NONE;
                        err_code_next = ERR_DWELL;
                    end else begin
                        dwell_incr = 1'b1;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
        locked_next = (state_next == MON_GREEN) || (state_next == MON_YELLOW) ||
                      (state_next == MON_RED);
        error_next  = (state_next == MON_FAULT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg       <= MON_UNLOCKED;
            phase_reg       <= PH_NONE;
            err_code_reg    <= ERR_NONE;
            cycle_count_reg <= '0;
            locked_reg      <= 1'b0;
            error_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            phase_reg       <= phase_next;
            err_code_reg    <= err_code_next;
            cycle_count_reg <= cycle_count_next;
            locked_reg      <= locked_next;
            error_reg       <= error_next;
        end
    end

    assign locked      = locked_reg;
    assign phase       = phase_reg;
    assign error       = error_reg;
    assign err_code    = err_code_reg;
    assign cycle_count = cycle_count_reg;

endmodule

// File: doc/lamp_sequence_monitor.md
Name: lamp_sequence_monitor

Overview:
- Receiving end of the three-lamp traffic-light bus: samples the one-hot `light[0:2]` output of the cyclic lamp controller each clock.
- Locks onto the GREEN -> YELLOW -> RED -> GREEN sequence, reports the current phase and counts completed cycles.
- Flags malformed codes, out-of-order transitions and (optionally) stuck lamps.
- Sits beside the lamp controller as a self-check / supervisory block.

Parameters:
- CNT_W, 8, width of the completed-cycle counter.
- MAX_DWELL, 1, maximum consecutive cycles one colour may be held (only used with the optional feature); legal range 1..255.

Ports:
- clock  input  1  rising-edge system clock.
- reset_n  input  1  asynchronous active-low reset.
- light  input  [0:2]  lamp bus; RED=3'b100, GREEN=3'b010, YELLOW=3'b001 (bit 0 = red).
- err_clr  input  1  single-cycle pulse; clears the fault and returns the monitor to unlocked.
- locked  output  1  high while the monitor is tracking a valid sequence.
- phase  output  2  current colour: 0=GREEN, 1=YELLOW, 2=RED, 3=NONE.
- error  output  1  sticky fault flag.
- err_code  output  2  0=none, 1=not one-hot, 2=illegal transition, 3=dwell exceeded.
- cycle_count  output  CNT_W  completed RED->GREEN transitions, saturating.

Behaviour:
- Reset (async assert, synchronous to clock on release): state=UNLOCKED, locked=0, phase=3, error=0, err_code=0, cycle_count=0, dwell count=0.
- All outputs are registered. A `light` value sampled at edge N is reflected in the outputs from edge N onward, i.e. visible during cycle N+1. There is no further pipelining.
- States: UNLOCKED, PH_GREEN, PH_YELLOW, PH_RED, FAULT.
- UNLOCKED:
  - A non-one-hot sample (000, or more than one bit set) is ignored; this absorbs X/garbage out of driver reset.
  - A valid colour moves to the matching PH_* state, sets locked=1 and phase to that colour, and sets dwell=1.
- PH_x, same colour sampled again:
  - Hold: dwell increments, saturating at 255.
- PH_x, legal successor sampled (GREEN->YELLOW, YELLOW->RED, RED->GREEN):
  - Advance; dwell=1.
  - On RED->GREEN only, cycle_count increments, saturating at all-ones.
- PH_x, non-one-hot sample:
  - Go to FAULT with err_code=1.
- PH_x, valid colour that is not the successor (e.g. GREEN->RED, YELLOW->GREEN):
  - Go to FAULT with err_code=2.
- FAULT:
  - error=1, locked=0, phase=3. Samples are ignored and err_code is frozen, so the first fault wins.
  - cycle_count is held, not cleared.
- err_clr:
  - Any state goes to UNLOCKED: error=0, err_code=0, phase=3, locked=0.
  - err_clr has priority over the sample on the same edge; that sample is not evaluated.
  - err_clr in UNLOCKED is a no-op.
- Reset mid-sequence returns immediately to the reset values, including cycle_count=0.
- With back-to-back single-cycle colours (the controller's native timing), the monitor stays locked indefinitely and cycle_count increments once every 3 clocks.

Optional Feature:
- Macro: LAMP_MON_DWELL_CHECK_EN.
- Defined: while in a PH_* state, a same-colour sample that would make dwell exceed MAX_DWELL moves to FAULT with err_code=3. Evaluation order: err_clr, then one-hot check, then transition check, then dwell check.
- Undefined: no dwell counter is instantiated and holds are unlimited; err_code=3 is never produced.

Decomposition:
- Shared package `lamp_pkg`:
  - Colour constants LIGHT_RED, LIGHT_GREEN, LIGHT_YELLOW.
  - Phase encodings PH_GREEN=0, PH_YELLOW=1, PH_RED=2, PH_NONE=3.
  - Error codes ERR_NONE, ERR_ONEHOT, ERR_TRANS, ERR_DWELL.
  - Monitor state enum.
  - The lamp controller's RED/GREEN/YELLOW parameters move here as well.
- One sub-module, `lamp_dwell_counter`: a saturating 8-bit counter with load-1 and increment inputs and an `over` compare against MAX_DWELL. It is instantiated only under LAMP_MON_DWELL_CHECK_EN.

Test Plan:
- Reset released, light=000 for 3 cycles, then 010, 001, 100, 010 -> locked=1 after the first 010, phase 0,1,2,0, cycle_count=1, error=0.
- Stream G,Y,R repeated 300 cycles with CNT_W=8 -> cycle_count reaches 255 and holds (saturates), no error.
- Locked in PH_GREEN, drive 100 -> next cycle error=1, err_code=2, locked=0, phase=3; then drive 011 -> err_code stays 2.
- Locked, drive 110 -> error=1, err_code=1. Pulse err_clr together with a sample of 010 -> UNLOCKED, error=0 (sample ignored). Next sample 010 -> locked, phase=0.
- With LAMP_MON_DWELL_CHECK_EN and MAX_DWELL=2: drive 001,001 -> no error; a third 001 -> err_code=3. Without the macro, the same stimulus gives error=0.
- Assert reset_n=0 asynchronously mid-cycle after cycle_count=5 -> all outputs return to reset values immediately, before the next clock edge.
